// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} piso_state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit counter for one serial frame: cleared when a word is loaded, advanced
// on each consumed bit, and flags the final data bit of the word.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int MSB = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = $clog2(MSB + 1);

  logic [CW-1:0] cnt;

  // Count consumed data bits; a load restarts the count from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(MSB - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter. Takes a word on a valid/ready
// handshake and emits it one bit per enabled clock, MSB-first or LSB-first.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to each
// frame; without it the frame is data bits only.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int MSB = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [MSB-1:0] din,
  input  logic           dir,
  input  logic           en,
  output logic           sout,
  output logic           sout_valid,
  output logic           busy,
  output logic           done
);

  piso_state_e    state_q;
  piso_state_e    state_d;
  logic [MSB-1:0] shreg;
  logic           dir_q;
  logic           last;
  logic           load_fire;
  logic           shift_fire;
  logic           frame_end;
`ifdef PISO_PARITY_EN
  logic           parity_q;
`endif

  assign load_fire  = load_valid && (state_q == IDLE);
  assign shift_fire = en && (state_q == SHIFT);
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);

  piso_bit_cnt #(
    .MSB (MSB)
  ) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_fire),
    .inc  (shift_fire),
    .last (last)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; frame_end marks the edge that consumes the final frame bit.
  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en && last) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d   = IDLE;
          frame_end = 1'b1;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (en) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Serial output selection; the line is forced low outside a frame.
  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    case (state_q)
      SHIFT: begin
        sout_valid = 1'b1;
        sout       = (dir_q == DIR_MSB_FIRST) ? shreg[MSB-1] : shreg[0];
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        sout_valid = 1'b1;
        sout       = parity_q;
      end
`endif
      default: begin
        sout       = 1'b0;
        sout_valid = 1'b0;
      end
    endcase
  end

  // Shift register and captured direction; the word only moves on a consumed bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      dir_q <= DIR_MSB_FIRST;
    end else if (load_fire) begin
      shreg <= din;
      dir_q <= dir;
    end else if (shift_fire) begin
      if (dir_q == DIR_LSB_FIRST) begin
        shreg <= {1'b0, shreg[MSB-1:1]};
      end else begin
        shreg <= {shreg[MSB-2:0], 1'b0};
      end
    end
  end

`ifdef PISO_PARITY_EN
  // Even-parity bit of the loaded word, captured alongside the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else if (load_fire) begin
      parity_q <= ^din;
    end
  end
`endif

  // One-cycle completion pulse, coincident with the return to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= frame_end;
    end
  end

endmodule
